// File: rtl/shift_bit_unit_pkg.sv
// Shared types and helpers for the multi-cycle shift/bit unit.
package sbu_pkg;

    // Operation codes; 11..15 are illegal and pass operand and flags through.
    typedef enum logic [3:0] {
        SBU_RLC  = 4'd0,
        SBU_RRC  = 4'd1,
        SBU_RL   = 4'd2,
        SBU_RR   = 4'd3,
        SBU_SLA  = 4'd4,
        SBU_SRA  = 4'd5,
        SBU_SWAP = 4'd6,
        SBU_SRL  = 4'd7,
        SBU_BIT  = 4'd8,
        SBU_RES  = 4'd9,
        SBU_SET  = 4'd10
    } sbu_op_e;

    // Bit positions inside the {Z,N,H,C} flag nibble.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sbu_state_e;

    // True for the ops that run one bit per cycle under a count.
    function automatic logic is_shift_op(input logic [3:0] op);
        case (op)
            SBU_RLC, SBU_RRC, SBU_RL, SBU_RR,
            SBU_SLA, SBU_SRA, SBU_SRL: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Packs individual flags into the {Z,N,H,C} nibble.
    function automatic logic [3:0] make_flags(input logic z, input logic n,
                                              input logic h, input logic c);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_H] = h;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/shift_bit_unit_if.sv
// Request/response bundle between a requester and the shift/bit unit.
interface shift_bit_unit_if #(
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(WIDTH);

    logic             i_Valid;
    logic             o_Ready;
    logic [3:0]       i_Op;
    logic [WIDTH-1:0] i_A;
    logic [3:0]       i_F;
    logic [AW-1:0]    i_Arg;
    logic             i_Disable_Z;
    logic             o_Valid;
    logic             i_Ready;
    logic [WIDTH-1:0] o_A;
    logic [3:0]       o_F;

    modport master (
        output i_Valid, i_Op, i_A, i_F, i_Arg, i_Disable_Z, i_Ready,
        input  o_Ready, o_Valid, o_A, o_F
    );

    modport slave (
        input  i_Valid, i_Op, i_A, i_F, i_Arg, i_Disable_Z, i_Ready,
        output o_Ready, o_Valid, o_A, o_F
    );
endinterface

// File: rtl/shift_bit_unit_step.sv
// One single-bit shift/rotate step; purely combinational.
module sbu_step
    import sbu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] value_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] value_out,
    output logic             carry_out
);

    // Select the shifted value and the bit that falls off the end.
    always_comb begin
        value_out = value_in;
        carry_out = carry_in;
        case (op)
            SBU_RLC: begin
                value_out = {value_in[WIDTH-2:0], value_in[WIDTH-1]};
                carry_out = value_in[WIDTH-1];
            end
            SBU_RRC: begin
                value_out = {value_in[0], value_in[WIDTH-1:1]};
                carry_out = value_in[0];
            end
            SBU_RL: begin
                value_out = {value_in[WIDTH-2:0], carry_in};
                carry_out = value_in[WIDTH-1];
            end
            SBU_RR: begin
                value_out = {carry_in, value_in[WIDTH-1:1]};
                carry_out = value_in[0];
            end
            SBU_SLA: begin
                value_out = {value_in[WIDTH-2:0], 1'b0};
                carry_out = value_in[WIDTH-1];
            end
            SBU_SRA: begin
                value_out = {value_in[WIDTH-1], value_in[WIDTH-1:1]};
                carry_out = value_in[0];
            end
            SBU_SRL: begin
                value_out = {1'b0, value_in[WIDTH-1:1]};
                carry_out = value_in[0];
            end
            default: begin
                value_out = value_in;
                carry_out = carry_in;
            end
        endcase
    end

endmodule

// File: rtl/shift_bit_unit.sv
// Multi-cycle rotate/shift/bit unit: one shift step per clock, results held
// in output registers until the consumer takes them.
module shift_bit_unit
    import sbu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    shift_bit_unit_if.slave    bus
);
    localparam int AW = $clog2(WIDTH);

    sbu_state_e       state_r, state_nxt_s;
    logic [3:0]       op_r, op_nxt_s;
    logic [WIDTH-1:0] val_r, val_nxt_s;
    logic             carry_r, carry_nxt_s;
    logic [AW-1:0]    cnt_r, cnt_nxt_s;
    logic             dz_r, dz_nxt_s;
    logic [WIDTH-1:0] a_out_r, a_out_nxt_s;
    logic [3:0]       f_out_r, f_out_nxt_s;
    logic             ready_r, valid_r;

    logic             busy_s;
    logic [3:0]       step_op_s;
    logic [WIDTH-1:0] step_in_s, step_out_s;
    logic             step_cin_s, step_cout_s;
    logic [WIDTH-1:0] bit_mask_s;
    logic             step_zero_s;

    // The single step engine serves the accept edge (fresh operand) and the
    // BUSY cycles (chained value and carry).
    assign busy_s      = (state_r == ST_BUSY);
    assign step_op_s   = busy_s ? op_r    : bus.i_Op;
    assign step_in_s   = busy_s ? val_r   : bus.i_A;
    assign step_cin_s  = busy_s ? carry_r : bus.i_F[FLAG_C];
    assign step_zero_s = (step_out_s == {WIDTH{1'b0}});
    assign bit_mask_s  = {{(WIDTH-1){1'b0}}, 1'b1} << bus.i_Arg;

    sbu_step #(.WIDTH(WIDTH)) u_step (
        .op        (step_op_s),
        .value_in  (step_in_s),
        .carry_in  (step_cin_s),
        .value_out (step_out_s),
        .carry_out (step_cout_s)
    );

    // Next-state and datapath decode for IDLE/BUSY/DONE.
    always_comb begin
        state_nxt_s = state_r;
        op_nxt_s    = op_r;
        val_nxt_s   = val_r;
        carry_nxt_s = carry_r;
        cnt_nxt_s   = cnt_r;
        dz_nxt_s    = dz_r;
        a_out_nxt_s = a_out_r;
        f_out_nxt_s = f_out_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_Valid) begin
                    op_nxt_s = bus.i_Op;
                    dz_nxt_s = bus.i_Disable_Z;
                    if (is_shift_op(bus.i_Op)) begin
                        if (bus.i_Arg == {AW{1'b0}}) begin
                            // Zero count: operand and carry pass through.
                            a_out_nxt_s = bus.i_A;
                            f_out_nxt_s = make_flags((bus.i_A == {WIDTH{1'b0}}) & ~bus.i_Disable_Z,
                                                     1'b0, 1'b0, bus.i_F[FLAG_C]);
                            state_nxt_s = ST_DONE;
                        end else if (bus.i_Arg == AW'(1)) begin
                            a_out_nxt_s = step_out_s;
                            f_out_nxt_s = make_flags(step_zero_s & ~bus.i_Disable_Z,
                                                     1'b0, 1'b0, step_cout_s);
                            state_nxt_s = ST_DONE;
                        end else begin
                            // First step already done; count holds steps left.
                            val_nxt_s   = step_out_s;
                            carry_nxt_s = step_cout_s;
                            cnt_nxt_s   = bus.i_Arg - AW'(1);
                            state_nxt_s = ST_BUSY;
                        end
                    end else begin
                        state_nxt_s = ST_DONE;
                        case (bus.i_Op)
                            SBU_SWAP: begin
                                a_out_nxt_s = {bus.i_A[WIDTH/2-1:0], bus.i_A[WIDTH-1:WIDTH/2]};
                                f_out_nxt_s = make_flags(bus.i_A == {WIDTH{1'b0}},
                                                         1'b0, 1'b0, 1'b0);
                            end
                            SBU_BIT: begin
                                a_out_nxt_s = bus.i_A;
                                f_out_nxt_s = make_flags(~bus.i_A[bus.i_Arg], 1'b0, 1'b1,
                                                         bus.i_F[FLAG_C]);
                            end
                            SBU_RES: begin
                                a_out_nxt_s = bus.i_A & ~bit_mask_s;
                                f_out_nxt_s = bus.i_F;
                            end
                            SBU_SET: begin
                                a_out_nxt_s = bus.i_A | bit_mask_s;
                                f_out_nxt_s = bus.i_F;
                            end
                            default: begin
                                a_out_nxt_s = bus.i_A;
                                f_out_nxt_s = bus.i_F;
                            end
                        endcase
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == AW'(1)) begin
                    a_out_nxt_s = step_out_s;
                    f_out_nxt_s = make_flags(step_zero_s & ~dz_r, 1'b0, 1'b0, step_cout_s);
                    state_nxt_s = ST_DONE;
                end else begin
                    val_nxt_s   = step_out_s;
                    carry_nxt_s = step_cout_s;
                    cnt_nxt_s   = cnt_r - AW'(1);
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (bus.i_Ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, working and output registers; reset aborts any op in flight.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_r <= ST_IDLE;
            op_r    <= 4'd0;
            val_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {AW{1'b0}};
            dz_r    <= 1'b0;
            a_out_r <= {WIDTH{1'b0}};
            f_out_r <= 4'b0000;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            op_r    <= op_nxt_s;
            val_r   <= val_nxt_s;
            carry_r <= carry_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dz_r    <= dz_nxt_s;
            a_out_r <= a_out_nxt_s;
            f_out_r <= f_out_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.o_Ready = ready_r;
    assign bus.o_Valid = valid_r;
    assign bus.o_A     = a_out_r;
    assign bus.o_F     = f_out_r;

endmodule

// File: tb/tb_shift_bit_unit.sv
// Directed bench for shift_bit_unit at WIDTH=8 and WIDTH=16.
module tb_shift_bit_unit;
    import sbu_pkg::*;

    logic clk;
    logic rst8;
    logic rst16;
    int   checks;
    int   errors;

    shift_bit_unit_if #(.WIDTH(8))  if8 ();
    shift_bit_unit_if #(.WIDTH(16)) if16 ();

    shift_bit_unit #(.WIDTH(8))  dut8  (.i_Clk(clk), .i_Reset(rst8),  .bus(if8.slave));
    shift_bit_unit #(.WIDTH(16)) dut16 (.i_Clk(clk), .i_Reset(rst16), .bus(if16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 8-bit unit, check latency/result, optionally
    // hold backpressure for `hold` cycles while offering junk requests.
    task automatic do8(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [3:0] f, input logic [2:0] arg, input logic dz,
                       input logic [7:0] ea, input logic [3:0] ef, input int elat,
                       input int hold);
        int lat;
        @(negedge clk);
        check({tag, ".ready"}, {31'd0, if8.o_Ready}, 32'd1);
        if8.i_Valid = 1'b1; if8.i_Op = op; if8.i_A = a; if8.i_F = f;
        if8.i_Arg = arg; if8.i_Disable_Z = dz;
        @(negedge clk);
        if8.i_Valid = 1'b0;
        lat = 1;
        while (if8.o_Valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, elat);
        check({tag, ".a"}, {24'd0, if8.o_A}, {24'd0, ea});
        check({tag, ".f"}, {28'd0, if8.o_F}, {28'd0, ef});
        for (int i = 0; i < hold; i++) begin
            if8.i_Valid = 1'b1; if8.i_Op = SBU_SWAP; if8.i_A = ~a;
            @(negedge clk);
            check({tag, ".hold_valid"}, {31'd0, if8.o_Valid}, 32'd1);
            check({tag, ".hold_ready"}, {31'd0, if8.o_Ready}, 32'd0);
            check({tag, ".hold_a"}, {24'd0, if8.o_A}, {24'd0, ea});
            check({tag, ".hold_f"}, {28'd0, if8.o_F}, {28'd0, ef});
        end
        if8.i_Valid = 1'b0;
        if8.i_Ready = 1'b1;
        @(negedge clk);
        if8.i_Ready = 1'b0;
        check({tag, ".drained"}, {31'd0, if8.o_Valid}, 32'd0);
    endtask

    // Issue one op on the 16-bit unit and check latency/result.
    task automatic do16(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [3:0] f, input logic [3:0] arg, input logic dz,
                        input logic [15:0] ea, input logic [3:0] ef, input int elat);
        int lat;
        @(negedge clk);
        check({tag, ".ready"}, {31'd0, if16.o_Ready}, 32'd1);
        if16.i_Valid = 1'b1; if16.i_Op = op; if16.i_A = a; if16.i_F = f;
        if16.i_Arg = arg; if16.i_Disable_Z = dz;
        @(negedge clk);
        if16.i_Valid = 1'b0;
        lat = 1;
        while (if16.o_Valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, elat);
        check({tag, ".a"}, {16'd0, if16.o_A}, {16'd0, ea});
        check({tag, ".f"}, {28'd0, if16.o_F}, {28'd0, ef});
        if16.i_Ready = 1'b1;
        @(negedge clk);
        if16.i_Ready = 1'b0;
        check({tag, ".drained"}, {31'd0, if16.o_Valid}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst8 = 1'b1; rst16 = 1'b1;
        if8.i_Valid = 1'b0;  if8.i_Op = 4'd0;  if8.i_A = 8'h00;   if8.i_F = 4'b0000;
        if8.i_Arg = 3'd0;    if8.i_Disable_Z = 1'b0;  if8.i_Ready = 1'b0;
        if16.i_Valid = 1'b0; if16.i_Op = 4'd0; if16.i_A = 16'h0000; if16.i_F = 4'b0000;
        if16.i_Arg = 4'd0;   if16.i_Disable_Z = 1'b0; if16.i_Ready = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst16 = 1'b0;

        // Reset state
        check("rst.ready8",  {31'd0, if8.o_Ready},  32'd1);
        check("rst.valid8",  {31'd0, if8.o_Valid},  32'd0);
        check("rst.a8",      {24'd0, if8.o_A},      32'd0);
        check("rst.f8",      {28'd0, if8.o_F},      32'd0);
        check("rst.ready16", {31'd0, if16.o_Ready}, 32'd1);
        check("rst.valid16", {31'd0, if16.o_Valid}, 32'd0);

        // 8-bit shifts and bit ops (RLC case also exercises 5 cycles of backpressure)
        do8("rlc1",  SBU_RLC, 8'h85, 4'b0000, 3'd1, 1'b0, 8'h0B, 4'b0001, 1, 5);
        do8("rr3",   SBU_RR,  8'h01, 4'b0000, 3'd3, 1'b0, 8'h40, 4'b0000, 3, 0);
        do8("rr_dz", SBU_RR,  8'h00, 4'b0000, 3'd1, 1'b1, 8'h00, 4'b0000, 1, 0);
        do8("sla2",  SBU_SLA, 8'h40, 4'b0000, 3'd2, 1'b0, 8'h00, 4'b1001, 2, 0);
        do8("rl2",   SBU_RL,  8'h80, 4'b0000, 3'd2, 1'b0, 8'h01, 4'b0000, 2, 0);
        do8("srl7",  SBU_SRL, 8'h81, 4'b0000, 3'd7, 1'b0, 8'h01, 4'b0000, 7, 0);
        do8("bit7",  SBU_BIT, 8'h7F, 4'b0001, 3'd7, 1'b0, 8'h7F, 4'b1011, 1, 0);
        do8("res0",  SBU_RES, 8'hFF, 4'b1010, 3'd0, 1'b0, 8'hFE, 4'b1010, 1, 0);
        do8("illeg", 4'd12,   8'h5A, 4'b0101, 3'd3, 1'b0, 8'h5A, 4'b0101, 1, 0);

        // 16-bit ops
        do16("sra15", SBU_SRA,  16'h8000, 4'b0000, 4'd15, 1'b0, 16'hFFFF, 4'b0000, 15);
        do16("sra0",  SBU_SRA,  16'h8000, 4'b0001, 4'd0,  1'b0, 16'h8000, 4'b0001, 1);
        do16("rrc4",  SBU_RRC,  16'h000F, 4'b0000, 4'd4,  1'b0, 16'hF000, 4'b0001, 4);
        do16("swap",  SBU_SWAP, 16'h12AB, 4'b0000, 4'd3,  1'b0, 16'hAB12, 4'b0000, 1);
        do16("swap0", SBU_SWAP, 16'h0000, 4'b0000, 4'd0,  1'b1, 16'h0000, 4'b1000, 1);
        do16("set15", SBU_SET,  16'h0000, 4'b0110, 4'd15, 1'b0, 16'h8000, 4'b0110, 1);

        // Reset in the middle of a count-7 op aborts it
        @(negedge clk);
        if8.i_Valid = 1'b1; if8.i_Op = SBU_SLA; if8.i_A = 8'h01; if8.i_F = 4'b0000;
        if8.i_Arg = 3'd7; if8.i_Disable_Z = 1'b0;
        @(negedge clk);
        if8.i_Valid = 1'b0;
        @(negedge clk);
        check("abort.busy", {31'd0, if8.o_Ready}, 32'd0);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        check("abort.valid", {31'd0, if8.o_Valid}, 32'd0);
        check("abort.ready", {31'd0, if8.o_Ready}, 32'd1);
        check("abort.a",     {24'd0, if8.o_A},     32'd0);
        check("abort.f",     {28'd0, if8.o_F},     32'd0);
        repeat (8) @(negedge clk);
        check("abort.no_late_valid", {31'd0, if8.o_Valid}, 32'd0);

        // Reset and request on the same edge: request is dropped
        if8.i_Valid = 1'b1; if8.i_Op = SBU_SWAP; if8.i_A = 8'h3C; if8.i_Arg = 3'd0;
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        if8.i_Valid = 1'b0;
        check("rstvalid.valid", {31'd0, if8.o_Valid}, 32'd0);
        @(negedge clk);
        check("rstvalid.dropped", {31'd0, if8.o_Valid}, 32'd0);

        // Unit still works after the abort
        do8("post_rst", SBU_SWAP, 8'h3C, 4'b0000, 3'd0, 1'b0, 8'hC3, 4'b0000, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_bit_unit.md
# shift_bit_unit

Parametrised, multi-cycle successor to the CPU's single-cycle rotate/shift/bit logic unit. It executes RLC/RRC/RL/RR/SLA/SRA/SRL by an arbitrary count, one bit per cycle, plus SWAP, BIT, RES and SET on a WIDTH-bit operand. A valid/ready handshake brackets each operation, and the result and flags stay registered until they are consumed. It sits beside the 8-bit ALU and serves both the CB-prefix datapath and the planned 16-bit extension ops.

## Interface
- WIDTH, 8, operand width; power of two, 8..32.
- AW, $clog2(WIDTH), width of count/bit-index field (derived, not overridden).
- i_Clk  input  1  system clock, rising edge.
- i_Reset  input  1  reset; synchronous and active-high; one clock, no other clock domains.
- i_Valid  input  1  request present.
- o_Ready  output  1  unit can accept a request.
- i_Op  input  4  operation code (package enum).
- i_A  input  WIDTH  operand.
- i_F  input  4  old flags {Z,N,H,C}.
- i_Arg  input  AW  shift count (shift ops) or bit index (BIT/RES/SET).
- i_Disable_Z  input  1  force Z=0 on shift/rotate results (non-CB opcodes).
- o_Valid  output  1  result available.
- i_Ready  input  1  consumer takes result.
- o_A  output  WIDTH  result.
- o_F  output  4  new flags {Z,N,H,C}.

## Operation
- Op codes: 0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SWAP, 7 SRL, 8 BIT, 9 RES, 10 SET, 11..15 illegal.
- States: IDLE, BUSY, DONE. o_Ready = (state==IDLE). o_Valid = (state==DONE).
- Accept: i_Valid & o_Ready at a rising edge latches op, operand, flags, Disable_Z and count. i_Valid is ignored outside IDLE.
- Shift ops, count N≥1: the first step executes on the accept edge, then one step per edge. Transitions: IDLE→BUSY if N>1, IDLE→DONE if N==1; BUSY→DONE on the edge that executes step N.
- Per-step rules:
  - RLC/RRC rotate WIDTH bits; C = bit rotated.
  - RL/RR rotate through WIDTH+1 bits (operand+C); the carry register chains between steps.
  - SLA shifts in 0.
  - SRA replicates the MSB.
  - SRL shifts in 0.
  - C = last bit shifted out.
- Shift count 0: result = i_A; C = i_F[0].
- Shift flags: Z = (result==0) & ~i_Disable_Z; N = 0; H = 0.
- SWAP: exchanges the WIDTH/2 halves. Flags = {result==0, 0, 0, 0}; i_Disable_Z is ignored.
- BIT: result = i_A; flags = {~i_A[i_Arg], 0, 1, i_F[0]}.
- RES/SET: clear/set bit i_Arg; flags = i_F.
- Illegal ops: result = i_A, flags = i_F.
- SWAP, BIT, RES, SET and illegal ops go IDLE→DONE on the accept edge; i_Arg is not a count for these ops.
- DONE→IDLE on an edge with i_Ready. While i_Ready is low, o_A/o_F/o_Valid hold stable indefinitely.

## Timing
- Reset (synchronous, evaluated every edge, highest priority): state=IDLE; o_A=0; o_F=0; o_Valid=0; o_Ready=1 from the next cycle. This aborts a BUSY or DONE op; no partial result is emitted.
- Latency from accept edge to o_Valid high: max(N,1) cycles for shift ops; 1 cycle for all others.
- Throughput: at least one bubble cycle per op, because DONE→IDLE costs one edge. The earliest next accept is the edge after the i_Ready handshake.
- o_A/o_F are undefined-but-stable in BUSY; the bench checks them only when o_Valid is high.
- Count arithmetic is AW bits, unsigned. N = WIDTH-1 is the maximum (e.g. 7 for WIDTH=8). The remaining-step counter decrements to 0 with no wrap.
- Simultaneous i_Reset and i_Valid: reset wins and the request is dropped.

## Structure
- Package `sbu_pkg`: op enum (`SBU_RLC`..`SBU_SET`), flag bit positions (`FLAG_Z`=3, `FLAG_N`=2, `FLAG_H`=1, `FLAG_C`=0), state enum.
- One sub-module `sbu_step`: purely combinational single-bit shift/rotate step (inputs op, value, carry-in; outputs value, carry-out), parametrised by WIDTH.
- The top level holds the FSM, operand/carry/count registers, SWAP/BIT/RES/SET logic and the output registers.

## Test plan
- WIDTH=8, RLC, A=0x85, count 1 → o_A=0x0B, o_F=0001, o_Valid 1 cycle after accept.
- WIDTH=8, RR, A=0x01, F.C=0, count 3 → o_A=0x40, o_F=0000, o_Valid 3 cycles after accept; repeat with i_Disable_Z=1 and A=0x00, count 1, F.C=0 → o_F=0000.
- WIDTH=16, SRA, A=0x8000, count 15 → o_A=0xFFFF, o_F=0000, latency 15; count 0 with F=0001 → o_A=0x8000, o_F=0001.
- WIDTH=16, SWAP, A=0x12AB → 0xAB12, o_F=0000; SWAP, A=0, i_Disable_Z=1 → o_F=1000.
- WIDTH=8, BIT, idx 7, A=0x7F, F=0001 → o_A=0x7F, o_F=1011; WIDTH=16, SET, idx 15, A=0x0000, F=0110 → o_A=0x8000, o_F=0110.
- Backpressure and reset:
  - Hold i_Ready=0 for 5 cycles in DONE → outputs stable, o_Ready=0, i_Valid ignored.
  - Assert i_Reset during BUSY of a count-7 op → next cycle state IDLE, o_Valid=0, o_A=0, o_F=0, o_Ready=1.
